addr_seg_decoder: RTL and testbench
===================================

// Module: addr_seg_decoder
// PURPOSE
//  Inverse of the segment address-range select: takes an address stream, returns segment select (0..3) + offset in segment.
//  Segments: sel0=1..15, sel1=16..30, sel2=31..45, sel3=46..60. Any other address is out of range.
//  Sits between the address source and per-segment consumers. One registered stage with valid/ready handshake on both sides.
//  Optional per-segment hit counters flag when every address of a segment has passed.
// PARAMETERS
//  ADDR_W    8   address width
//  SEG_BASE  1   first address of segment 0
//  SEG_LEN   15  addresses per segment; segment k = [SEG_BASE+k*SEG_LEN, SEG_BASE+(k+1)*SEG_LEN-1]
//  SEL_W     2   select width; NUM_SEG = 2**SEL_W = 4
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  RSTn         in   1       asynchronous, active-low reset
//  in_valid     in   1       in_addr valid
//  in_ready     out  1       decoder can accept this cycle
//  in_addr      in   ADDR_W  address to decode
//  out_valid    out  1       decoded result valid
//  out_ready    in   1       downstream accepts result
//  out_select   out  SEL_W   segment index
//  out_offset   out  4       in_addr - segment start, 0..SEG_LEN-1
//  out_err      out  1       in_addr outside all segments
//  cnt_clr      in   1       sync clear of hit counters and seg_done
//  seg_done     out  4       bit k: all SEG_LEN addresses of segment k accepted (ADDR_SEG_CNT_EN only)
// BEHAVIOUR
//  Reset (RSTn=0, async): out_valid=0, out_select=0, out_offset=0, out_err=0, counters=0, seg_done=0.
//  in_ready = !out_valid || out_ready (combinational). Input handshake = in_valid && in_ready.
//  Latency 1: addr accepted at edge N -> out_valid=1 with its result after edge N. Full throughput 1/cycle.
//  Output holds stable (valid, select, offset, err) while out_valid && !out_ready.
//  Output handshake without new input -> out_valid=0 next cycle; data regs keep last value.
//  Decode uses range compares only, no divider/multiplier: sel = highest k with in_addr >= start_k, then range-check.
//  Out of range (0, or >= SEG_BASE+NUM_SEG*SEG_LEN, i.e. 61..255): out_err=1, out_select=0, out_offset=0.
//  Boundaries: 1->(0,0); 15->(0,14); 16->(1,0); 45->(2,14); 46->(3,0); 60->(3,14); 61->err.
//  Reset mid-transfer: pending result dropped, no counter update.
// CONFIGURATION
//  Macro ADDR_SEG_CNT_EN:
//   Defined: per segment a 4-bit hit counter increments on output handshake with out_err=0 for that segment;
//    saturates at SEG_LEN; seg_done[k] = (cnt_k == SEG_LEN). Counts transfers, not distinct addresses.
//    cnt_clr clears counters next edge; cnt_clr with a simultaneous increment -> clear wins (counter=0).
//    Error transfers never count.
//   Not defined: counters absent, seg_done tied 0, cnt_clr ignored. Decode path identical.
// STRUCTURE
//  Package addr_seg_pkg: ADDR_W, SEG_BASE, SEG_LEN, SEL_W, NUM_SEG, SEG_END=SEG_BASE+NUM_SEG*SEG_LEN-1, seg_start(k) function.
//  Sub-module addr_seg_lookup: combinational addr -> {err, select, offset}. Top holds handshake regs and counters.
// TESTING
//  Sweep in_addr 0..255, out_ready=1 -> each result next cycle; 0 and 61..255 err=1, 1..60 exact (sel,offset); boundaries above.
//  out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after first accept; output unchanged; no in_addr lost or duplicated.
//  Back-to-back 16,30,31 with out_ready=1 -> outputs (1,0),(1,14),(2,0) on consecutive cycles, in_ready stays 1.
//  CNT_EN: addrs 46..60 once each -> seg_done=4'b1000 after 15th handshake; extra 60 keeps saturation; cnt_clr -> seg_done=0.
//  CNT_EN: cnt_clr in same cycle as handshake of addr 5 -> segment 0 counter=0; addr 200 -> no counter changes.
//  RSTn low while out_valid=1 and out_ready=0 -> out_valid=0 immediately (async), counters 0; first accept after release decodes correctly.

Source files
------------

// File: rtl/addr_seg_pkg.sv
// Shared constants, result type and segment-start helper for the address segment decoder.
package addr_seg_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned SEG_BASE = 1;
    localparam int unsigned SEG_LEN  = 15;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned NUM_SEG  = 2 ** SEL_W;
    localparam int unsigned OFF_W    = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned SEG_END  = SEG_BASE + NUM_SEG * SEG_LEN - 1;

    typedef struct packed {
        logic             err;
        logic [SEL_W-1:0] sel;
        logic [OFF_W-1:0] off;
    } seg_res_t;

    // First address of segment k; only ever called with elaboration-time constants.
    function automatic logic [ADDR_W-1:0] seg_start(input int unsigned k);
        return ADDR_W'(SEG_BASE + k * SEG_LEN);
    endfunction

endpackage

// File: rtl/addr_seg_lookup.sv
// Combinational address -> {err, select, offset} lookup built from range compares only.
module addr_seg_lookup
    import addr_seg_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    output seg_res_t          res_o
);

    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] base;
    logic              in_range;

    // Pick the highest segment whose start is <= addr, then range-check the whole window.
    always_comb begin
        sel      = '0;
        base     = seg_start(0);
        in_range = (addr_i >= ADDR_W'(SEG_BASE)) && (addr_i <= ADDR_W'(SEG_END));
        for (int unsigned k = 0; k < NUM_SEG; k++) begin
            if (addr_i >= seg_start(k)) begin
                sel  = SEL_W'(k);
                base = seg_start(k);
            end
        end
        res_o.err = !in_range;
        res_o.sel = in_range ? sel : '0;
        res_o.off = in_range ? OFF_W'(addr_i - base) : '0;
    end

endmodule

// File: rtl/addr_seg_decoder.sv
// Address segment decoder: one registered stage with valid/ready on both sides.
// Optional per-segment hit counters and seg_done flags are enabled by ADDR_SEG_CNT_EN.
module addr_seg_decoder
    import addr_seg_pkg::*;
(
    input  logic               clk,
    input  logic               RSTn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_select,
    output logic [OFF_W-1:0]   out_offset,
    output logic               out_err,
    input  logic               cnt_clr,
    output logic [NUM_SEG-1:0] seg_done
);

    seg_res_t lut_res;
    seg_res_t res_q, res_d;
    logic     out_valid_q, out_valid_d;
    logic     in_hs;

    addr_seg_lookup u_lookup (
        .addr_i (in_addr),
        .res_o  (lut_res)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign in_hs    = in_valid && in_ready;

    // Load a new result on input handshake; drop valid once downstream takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        if (in_hs) begin
            out_valid_d = 1'b1;
            res_d       = lut_res;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_select = res_q.sel;
    assign out_offset = res_q.off;
    assign out_err    = res_q.err;

`ifdef ADDR_SEG_CNT_EN
    logic             out_hs;
    logic [CNT_W-1:0] cnt_q [NUM_SEG];
    logic [CNT_W-1:0] cnt_d [NUM_SEG];

    assign out_hs = out_valid_q && out_ready;

    // Count delivered in-range results per segment, saturating; clear has priority.
    always_comb begin
        for (int unsigned k = 0; k < NUM_SEG; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (out_hs && !res_q.err && (res_q.sel == SEL_W'(k)) &&
                         (cnt_q[k] != CNT_W'(SEG_LEN))) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    // Hit counter registers.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int unsigned k = 0; k < NUM_SEG; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_SEG; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // A segment is done once its counter has reached the segment length.
    always_comb begin
        for (int unsigned k = 0; k < NUM_SEG; k++) begin
            seg_done[k] = (cnt_q[k] == CNT_W'(SEG_LEN));
        end
    end
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign seg_done       = '0;
`endif

endmodule

// File: tb/tb_addr_seg_decoder.sv
// Self-checking bench for addr_seg_decoder: directed steps plus random traffic against a
// transaction-level reference model. Counter checks follow ADDR_SEG_CNT_EN.
module tb_addr_seg_decoder;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_addr = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_select;
    logic [3:0] out_offset;
    logic       out_err;
    logic       cnt_clr = 1'b0;
    logic [3:0] seg_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit mv;
    int m_sel;
    int m_off;
    bit m_err;
    int cnt[4];

    addr_seg_decoder dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_select (out_select),
        .out_offset (out_offset),
        .out_err    (out_err),
        .cnt_clr    (cnt_clr),
        .seg_done   (seg_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Segments of 15 addresses starting at 1; everything else is an error.
    function automatic void ref_decode(input int a, output int sel, output int off,
                                       output bit err);
        if (a >= 1 && a <= 60) begin
            sel = (a - 1) / 15;
            off = (a - 1) % 15;
            err = 1'b0;
        end else begin
            sel = 0;
            off = 0;
            err = 1'b1;
        end
    endfunction

    task automatic model_reset();
        mv    = 1'b0;
        m_sel = 0;
        m_off = 0;
        m_err = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
    endtask

    task automatic check_state();
        logic [3:0] exp_done;
        exp_done = 4'd0;
`ifdef ADDR_SEG_CNT_EN
        for (int i = 0; i < 4; i++) exp_done[i] = (cnt[i] == 15);
`endif
        chk("out_valid", out_valid, mv);
        chk("out_select", out_select, m_sel);
        chk("out_offset", out_offset, m_off);
        chk("out_err", out_err, m_err);
        chk("seg_done", seg_done, exp_done);
    endtask

    // One clock with the currently driven inputs; model advances alongside the DUT.
    task automatic cycle();
        logic exp_rdy;
        int   s;
        int   o;
        bit   e;
        #1;
        exp_rdy = !mv || out_ready;
        chk("in_ready", in_ready, exp_rdy);
`ifdef ADDR_SEG_CNT_EN
        if (cnt_clr) begin
            for (int i = 0; i < 4; i++) cnt[i] = 0;
        end else if (mv && out_ready && !m_err && cnt[m_sel] < 15) begin
            cnt[m_sel]++;
        end
`endif
        if (in_valid && exp_rdy) begin
            ref_decode(int'(in_addr), s, o, e);
            mv    = 1'b1;
            m_sel = s;
            m_off = o;
            m_err = e;
        end else if (out_ready) begin
            mv = 1'b0;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic drive(input bit v, input int a, input bit rdy, input bit clr);
        in_valid  = v;
        in_addr   = 8'(a);
        out_ready = rdy;
        cnt_clr   = clr;
        cycle();
    endtask

    initial begin
        // Reset state
        model_reset();
        #12;
        check_state();
        chk("reset_in_ready", in_ready, 1'b1);
        RSTn = 1'b1;
        @(posedge clk);
        #1;

        // Full sweep with downstream always ready
        for (int a = 0; a < 256; a++) drive(1'b1, a, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);

        // Back-to-back across a segment boundary
        drive(1'b1, 16, 1'b1, 1'b0);
        drive(1'b1, 30, 1'b1, 1'b0);
        drive(1'b1, 31, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);

        // Downstream stall: source holds each address until accepted
        drive(1'b1, 33, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 34, 1'b0, 1'b0);
        drive(1'b1, 34, 1'b1, 1'b0);
        drive(1'b1, 35, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);

        // Fill segment 3, saturate, then clear
        drive(1'b0, 0, 1'b1, 1'b1);
        for (int a = 46; a <= 60; a++) drive(1'b1, a, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b1, 60, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b1);

        // Clear coinciding with a counted handshake, then an error transfer
        drive(1'b1, 5, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b1);
        drive(1'b1, 200, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);

        // Random traffic, mostly near the valid window
        repeat (400) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 62)),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 30) == 0);
        end

        // Asynchronous reset while a result is stalled
        drive(1'b1, 17, 1'b1, 1'b0);
        drive(1'b1, 50, 1'b1, 1'b0);
        drive(1'b1, 51, 1'b0, 1'b0);
        RSTn = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("rst_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_state();
        RSTn = 1'b1;
        drive(1'b1, 45, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
